// File: rtl/apb_uart_regs_fifo.sv
// apb_uart_regs_fifo: APB register front end for a UART with TX and RX FIFOs.
//   APB:    psel_i/penable_i/pwrite_i/paddr_i/pwdata_i/pstrb_i -> prdata_o/pready_o/pslverr_o
//           (zero wait states; prdata_o/pslverr_o are valid in the access cycle)
//   TX:     tx_data_o/tx_valid_o (FIFO head), tx_ready_i pops, tx_done_i frame-sent pulse
//   RX:     rx_data_i/rx_valid_i strobe pushes, parity_error_i qualified by rx_valid_i
//   Config: data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o from CFG
//   irq_o:  registered OR of enabled sticky interrupt status bits
// Map: 0x00 TX_DATA WO, 0x04 RX_DATA RO, 0x08 CFG RW, 0x0C CTRL RW,
//      0x10 STT RO, 0x14 INT_EN RW, 0x18 INT_STT W1C.

// Pointer-based FIFO; the caller only asserts push/pop when legal.
module apb_uart_regs_fifo_q #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // A push into a full FIFO with a same-cycle pop overwrites the slot being
    // popped; the head is read combinationally before the edge, so it is safe.
    always_ff @(posedge clk) begin
        if (reset_n && push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];
endmodule

module apb_uart_regs_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [31:0]       pwdata_i,
    input  logic [3:0]        pstrb_i,
    output logic [31:0]       prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    input  logic              tx_done_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    input  logic              parity_error_i,
    output logic [1:0]        data_bit_num_o,
    output logic              stop_bit_num_o,
    output logic              parity_en_o,
    output logic              parity_type_o,
    output logic              irq_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0] cfg;
    logic       tx_en, rx_en, tx_flush, rx_flush;
    logic [3:0] int_en, int_stt, ist_set, ist_clr;

    logic access, wr_acc, rd_acc, reg_wr;
    logic is_tx, is_rx, is_cfg, is_ctrl, is_stt, is_ien, is_ist, mapped, err;

    logic              tx_push, tx_pop, tx_empty, tx_full;
    logic              rx_push, rx_pop, rx_empty, rx_full, overrun;
    logic [DATA_W-1:0] tx_head, rx_head;
    logic [LW-1:0]     tx_level, rx_level;
    logic [31:0]       stt;

    assign access = psel_i & penable_i;
    assign wr_acc = access & pwrite_i;
    assign rd_acc = access & ~pwrite_i;
    assign reg_wr = wr_acc & pstrb_i[0];   // every writable field lives in byte lane 0

    assign is_tx   = (paddr_i == ADDR_W'(32'h00));
    assign is_rx   = (paddr_i == ADDR_W'(32'h04));
    assign is_cfg  = (paddr_i == ADDR_W'(32'h08));
    assign is_ctrl = (paddr_i == ADDR_W'(32'h0C));
    assign is_stt  = (paddr_i == ADDR_W'(32'h10));
    assign is_ien  = (paddr_i == ADDR_W'(32'h14));
    assign is_ist  = (paddr_i == ADDR_W'(32'h18));
    assign mapped  = is_tx | is_rx | is_cfg | is_ctrl | is_stt | is_ien | is_ist;

    assign err = access & (~mapped
                         | (pwrite_i & (is_rx | is_stt))
                         | (~pwrite_i & is_tx)
                         | (pwrite_i & is_tx & pstrb_i[0] & tx_full)
                         | (~pwrite_i & is_rx & rx_empty));

    // Fullness/emptiness are pre-cycle; an RX push into a full FIFO is only
    // accepted when the same cycle pops.
    assign tx_push = wr_acc & is_tx & pstrb_i[0] & ~tx_full;
    assign tx_pop  = tx_valid_o & tx_ready_i;
    assign rx_pop  = rd_acc & is_rx & ~rx_empty;
    assign rx_push = rx_valid_i & rx_en & (~rx_full | rx_pop);
    assign overrun = rx_valid_i & rx_en & rx_full & ~rx_pop;

    apb_uart_regs_fifo_q #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
        .wdata(pwdata_i[DATA_W-1:0]), .head(tx_head), .empty(tx_empty), .full(tx_full),
        .level(tx_level)
    );

    apb_uart_regs_fifo_q #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
        .wdata(rx_data_i), .head(rx_head), .empty(rx_empty), .full(rx_full),
        .level(rx_level)
    );

    assign ist_set = {overrun, parity_error_i & rx_valid_i, rx_push & ~rx_flush, tx_done_i};
    assign ist_clr = (reg_wr && is_ist) ? pwdata_i[3:0] : 4'b0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg      <= '0;
            tx_en    <= 1'b0;
            rx_en    <= 1'b0;
            tx_flush <= 1'b0;
            rx_flush <= 1'b0;
            int_en   <= '0;
            int_stt  <= '0;
            irq_o    <= 1'b0;
        end else begin
            tx_flush <= 1'b0;
            rx_flush <= 1'b0;
            if (reg_wr && is_cfg) cfg <= pwdata_i[4:0];
            if (reg_wr && is_ctrl) begin
                tx_en    <= pwdata_i[0];
                rx_en    <= pwdata_i[1];
                tx_flush <= pwdata_i[2];
                rx_flush <= pwdata_i[3];
            end
            if (reg_wr && is_ien) int_en <= pwdata_i[3:0];
            // set events are ORed in after the clear so they win
            int_stt <= (int_stt & ~ist_clr) | ist_set;
            irq_o   <= |(int_stt & int_en);
        end
    end

    assign stt = {8'h00, 8'(rx_level), 8'(tx_level), 4'h0, rx_full, rx_empty, tx_full, tx_empty};

    always_comb begin
        prdata_o = '0;
        if (rd_acc && !err) begin
            case (1'b1)
                is_rx:   prdata_o = 32'(rx_head);
                is_cfg:  prdata_o = {27'h0, cfg};
                is_ctrl: prdata_o = {28'h0, rx_flush, tx_flush, rx_en, tx_en};
                is_stt:  prdata_o = stt;
                is_ien:  prdata_o = {28'h0, int_en};
                is_ist:  prdata_o = {28'h0, int_stt};
                default: prdata_o = '0;
            endcase
        end
    end

    assign pslverr_o      = err;
    assign pready_o       = 1'b1;
    assign tx_valid_o     = ~tx_empty & tx_en;
    assign tx_data_o      = tx_empty ? '0 : tx_head;
    assign data_bit_num_o = cfg[1:0];
    assign stop_bit_num_o = cfg[2];
    assign parity_en_o    = cfg[3];
    assign parity_type_o  = cfg[4];

    logic unused_bits;
    assign unused_bits = ^{pstrb_i[3:1], pwdata_i[31:8]};
endmodule

// File: tb/tb_apb_uart_regs_fifo.sv
module tb_apb_uart_regs_fifo;
    logic        clk = 0, reset_n = 0;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [11:0] paddr = 0;
    logic [31:0] pwdata = 0;
    logic [3:0]  pstrb = 0;
    logic [31:0] prdata_o;
    logic        pready_o, pslverr_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready = 0, tx_done = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_valid = 0, perr = 0;
    logic [1:0]  data_bit_num_o;
    logic        stop_bit_num_o, parity_en_o, parity_type_o, irq_o;

    int checks = 0, errors = 0;

    apb_uart_regs_fifo dut (
        .clk(clk), .reset_n(reset_n), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
        .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_o),
        .pready_o(pready_o), .pslverr_o(pslverr_o), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready), .tx_done_i(tx_done),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid), .parity_error_i(perr),
        .data_bit_num_o(data_bit_num_o), .stop_bit_num_o(stop_bit_num_o),
        .parity_en_o(parity_en_o), .parity_type_o(parity_type_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] A_TX = 12'h000, A_RX = 12'h004, A_CFG = 12'h008, A_CTRL = 12'h00C,
                            A_STT = 12'h010, A_IEN = 12'h014, A_IST = 12'h018;

    typedef struct packed {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // One APB transfer (setup + access). Optional side strobes ride on the access cycle.
    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] st, input logic done_p, input logic rx_p,
                       input logic [7:0] rx_b, output logic [31:0] rd, output logic er);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable = 1; tx_done = done_p; rx_valid = rx_p; rx_data = rx_b;
        #1;
        rd = prdata_o; er = pslverr_o;
        chk("pready", 32'(pready_o), 32'd1);
        @(posedge clk); #1;
        psel = 0; penable = 0; pwrite = 0; tx_done = 0; rx_valid = 0;
    endtask

    task automatic wreg(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] rd; logic er;
        apb(1, addr, wd, 4'hF, 0, 0, 8'h0, rd, er);
        chk($sformatf("wr_err@%03h", addr), 32'(er), 32'd0);
    endtask

    task automatic rreg(input logic [11:0] addr, input logic [31:0] exp, input logic exp_er, input string name);
        logic [31:0] rd; logic er;
        apb(0, addr, 32'h0, 4'h0, 0, 0, 8'h0, rd, er);
        chk({name, "_data"}, rd, exp);
        chk({name, "_err"}, 32'(er), 32'(exp_er));
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk); reset_n = 1;
    endtask

    task automatic rx_strobes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); rx_valid = 1; rx_data = base + 8'(i);
        end
        @(negedge clk); rx_valid = 0;
    endtask

    // Reference model for the randomized phase
    logic [7:0] txq[$], rxq[$];
    logic [3:0] ist_m;

    function automatic logic [31:0] stt_model();
        int t = txq.size(), r = rxq.size();
        return (32'(r) << 16) | (32'(t) << 8) | (32'(r == 8) << 3) | (32'(r == 0) << 2)
             | (32'(t == 8) << 1) | 32'(t == 0);
    endfunction

    initial begin
        logic [31:0] rd; logic er;

        vecs[0]  = '{0, A_STT,   32'h0,         4'h0, 32'h5,  0};
        vecs[1]  = '{1, A_CFG,   32'h1F,        4'hF, 32'h0,  0};
        vecs[2]  = '{0, A_CFG,   32'h0,         4'h0, 32'h1F, 0};
        vecs[3]  = '{1, A_CFG,   32'h13,        4'h2, 32'h0,  0};
        vecs[4]  = '{0, A_CFG,   32'h0,         4'h0, 32'h1F, 0};
        vecs[5]  = '{1, A_CFG,   32'hFFFF_FF16, 4'h1, 32'h0,  0};
        vecs[6]  = '{0, A_CFG,   32'h0,         4'h0, 32'h16, 0};
        vecs[7]  = '{0, A_TX,    32'h0,         4'h0, 32'h0,  1};
        vecs[8]  = '{1, A_STT,   32'h1,         4'hF, 32'h0,  1};
        vecs[9]  = '{1, A_RX,    32'h1,         4'hF, 32'h0,  1};
        vecs[10] = '{0, 12'h01C, 32'h0,         4'h0, 32'h0,  1};
        vecs[11] = '{0, 12'h002, 32'h0,         4'h0, 32'h0,  1};
        vecs[12] = '{0, A_RX,    32'h0,         4'h0, 32'h0,  1};
        vecs[13] = '{1, A_IEN,   32'hFFFF_FFFF, 4'hF, 32'h0,  0};
        vecs[14] = '{0, A_IEN,   32'h0,         4'h0, 32'hF,  0};
        vecs[15] = '{0, A_IST,   32'h0,         4'h0, 32'h0,  0};
        vecs[16] = '{0, A_CTRL,  32'h0,         4'h0, 32'h0,  0};
        vecs[17] = '{1, A_IEN,   32'h0,         4'hF, 32'h0,  0};

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_prdata", prdata_o, 0);
        chk("rst_pslverr", 32'(pslverr_o), 0);
        chk("rst_tx_valid", 32'(tx_valid_o), 0);
        chk("rst_tx_data", 32'(tx_data_o), 0);
        chk("rst_cfg_out", 32'({data_bit_num_o, stop_bit_num_o, parity_en_o, parity_type_o}), 0);
        chk("rst_irq", 32'(irq_o), 0);
        @(negedge clk); reset_n = 1;

        // register map vectors
        for (int i = 0; i < 18; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 0, 0, 8'h0, rd, er);
            chk($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
        end
        chk("cfg_data_bits", 32'(data_bit_num_o), 2);
        chk("cfg_stop", 32'(stop_bit_num_o), 1);
        chk("cfg_par_en", 32'(parity_en_o), 0);
        chk("cfg_par_type", 32'(parity_type_o), 1);

        // tx_done sticky bit: same-cycle set beats W1C, later W1C clears, irq follows a cycle later
        wreg(A_IST, 32'hF);
        wreg(A_IEN, 32'h1);
        @(negedge clk); tx_done = 1;
        @(negedge clk); tx_done = 0;
        @(negedge clk); #1;
        chk("done_irq_set", 32'(irq_o), 1);
        apb(1, A_IST, 32'h1, 4'hF, 1, 0, 8'h0, rd, er);
        rreg(A_IST, 32'h1, 0, "w1c_vs_set");
        apb(1, A_IST, 32'h1, 4'hF, 0, 0, 8'h0, rd, er);
        chk("irq_lag", 32'(irq_o), 1);
        @(posedge clk); #1;
        chk("irq_drop", 32'(irq_o), 0);
        wreg(A_IEN, 32'h0);

        // TX fill to full, overflow rejected
        for (int i = 0; i < 8; i++) wreg(A_TX, 32'hA0 + 32'(i));
        rreg(A_STT, 32'h0000_0806, 0, "tx_full_stt");
        apb(1, A_TX, 32'hA8, 4'h1, 0, 0, 8'h0, rd, er);
        chk("tx_push_full_err", 32'(er), 1);
        rreg(A_STT, 32'h0000_0806, 0, "tx_full_stt2");

        // TX drain one per cycle
        tx_ready = 1;
        wreg(A_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("tx_valid%0d", i), 32'(tx_valid_o), 1);
            chk($sformatf("tx_data%0d", i), 32'(tx_data_o), 32'hA0 + 32'(i));
            @(posedge clk); #1;
        end
        chk("tx_drained", 32'(tx_valid_o), 0);
        tx_ready = 0;

        // reset while TX holds 3 entries
        for (int i = 0; i < 3; i++) wreg(A_TX, 32'h50 + 32'(i));
        chk("tx_pre_rst_valid", 32'(tx_valid_o), 1);
        @(negedge clk); reset_n = 0;
        @(posedge clk); #1;
        chk("rst_tx_valid2", 32'(tx_valid_o), 0);
        chk("rst_tx_data2", 32'(tx_data_o), 0);
        @(negedge clk); reset_n = 1;
        rreg(A_STT, 32'h5, 0, "rst_stt2");

        // TX flush
        wreg(A_TX, 32'h11); wreg(A_TX, 32'h22);
        wreg(A_CTRL, 32'h4);
        rreg(A_CTRL, 32'h0, 0, "flush_selfclr");
        rreg(A_STT, 32'h5, 0, "flush_stt");

        // RX overrun
        wreg(A_IEN, 32'h8);
        wreg(A_CTRL, 32'h2);
        wreg(A_IST, 32'hF);
        rx_strobes(9, 8'h30);
        rreg(A_IST, 32'h0A, 0, "rx_overrun_ist");
        chk("rx_overrun_irq", 32'(irq_o), 1);
        for (int i = 0; i < 8; i++) rreg(A_RX, 32'h30 + 32'(i), 0, $sformatf("rx_rd%0d", i));
        rreg(A_RX, 32'h0, 1, "rx_rd_empty");

        // RX full with same-cycle push and pop
        rx_strobes(8, 8'h40);
        wreg(A_IST, 32'hF);
        apb(0, A_RX, 32'h0, 4'h0, 0, 1, 8'h77, rd, er);
        chk("rx_pushpop_data", rd, 32'h40);
        chk("rx_pushpop_err", 32'(er), 0);
        rreg(A_IST, 32'h2, 0, "rx_pushpop_ist");
        rreg(A_STT, 32'h0008_0009, 0, "rx_pushpop_stt");

        // randomized traffic vs queue model
        do_reset();
        wreg(A_CTRL, 32'h3);
        txq.delete(); rxq.delete(); ist_m = 0;
        for (int seg = 0; seg < 4; seg++) begin
            for (int c = 0; c < 150; c++) begin
                int op; logic rdy, rv, pe, tx_ok, rx_pop_m; logic [7:0] rb, wb;
                op  = $urandom_range(0, 3);
                rdy = ($urandom_range(0, 7) < (seg[0] ? 1 : 6));
                rv  = ($urandom_range(0, 7) < (seg[1] ? 6 : 2));
                pe  = ($urandom_range(0, 15) == 0);
                rb  = 8'($urandom); wb = 8'($urandom);
                @(negedge clk);
                tx_ready = rdy; rx_valid = rv; rx_data = rb; perr = pe;
                psel = (op != 0); penable = (op != 0);
                pwrite = (op == 1); paddr = (op == 1) ? A_TX : (op == 2) ? A_RX : A_STT;
                pwdata = 32'(wb); pstrb = 4'h1;
                #1;
                chk("rnd_tx_valid", 32'(tx_valid_o), 32'(txq.size() != 0));
                chk("rnd_tx_data", 32'(tx_data_o), (txq.size() != 0) ? 32'(txq[0]) : 0);
                case (op)
                    1: begin
                        chk("rnd_txw_err", 32'(pslverr_o), 32'(txq.size() == 8));
                        chk("rnd_txw_data", prdata_o, 0);
                    end
                    2: begin
                        chk("rnd_rx_err", 32'(pslverr_o), 32'(rxq.size() == 0));
                        chk("rnd_rx_data", prdata_o, (rxq.size() != 0) ? 32'(rxq[0]) : 0);
                    end
                    3: begin
                        chk("rnd_stt_err", 32'(pslverr_o), 0);
                        chk("rnd_stt", prdata_o, stt_model());
                    end
                    default: chk("rnd_idle_err", 32'(pslverr_o), 0);
                endcase
                // model update using pre-cycle occupancy
                tx_ok    = (op == 1) && (txq.size() < 8);
                rx_pop_m = (op == 2) && (rxq.size() != 0);
                if (txq.size() != 0 && rdy) void'(txq.pop_front());
                if (tx_ok) txq.push_back(wb);
                if (rv && (rxq.size() < 8 || rx_pop_m)) begin
                    ist_m[1] = 1;
                    if (rx_pop_m) void'(rxq.pop_front());
                    rxq.push_back(rb);
                end else begin
                    if (rv) ist_m[3] = 1;
                    if (rx_pop_m) void'(rxq.pop_front());
                end
                if (rv && pe) ist_m[2] = 1;
            end
        end
        @(negedge clk);
        psel = 0; penable = 0; rx_valid = 0; tx_ready = 0; perr = 0;
        rreg(A_IST, 32'(ist_m), 0, "rnd_ist");
        rreg(A_STT, stt_model(), 0, "rnd_stt_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_uart_regs_fifo.md
APB_UART_REGS_FIFO -- requirements
Module: apb_uart_regs_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; power of two, 2..128.
REQ-002 Parameter DATA_W, default 8: UART data width held per FIFO entry, 5..8.
REQ-003 Parameter ADDR_W, default 12: APB address width.
REQ-004 Clocking: one clock; reset is synchronous and active-low.
REQ-005 Port clk  in  1  clock; all state updates on the rising edge.
REQ-006 Port reset_n  in  1  synchronous active-low reset.
REQ-007 APB inputs, all in: psel_i 1, penable_i 1, pwrite_i 1, paddr_i ADDR_W, pwdata_i 32, pstrb_i 4.
REQ-008 APB outputs, all out: prdata_o 32, pready_o 1, pslverr_o 1.
REQ-009 TX side: tx_data_o out DATA_W (TX FIFO head); tx_valid_o out 1; tx_ready_i in 1; tx_done_i in 1 (frame-sent pulse).
REQ-010 RX side, all in: rx_data_i DATA_W; rx_valid_i 1 (one-cycle strobe); parity_error_i 1 (qualified by rx_valid_i).
REQ-011 Config outputs, all out: data_bit_num_o 2, stop_bit_num_o 1, parity_en_o 1, parity_type_o 1.
REQ-012 Port irq_o  out  1  level interrupt.

Function
REQ-013 Zero wait states; pready_o SHALL be 1 whenever psel_i&penable_i. Access = psel_i&penable_i.
REQ-014 Map: 0x00 TX_DATA WO; 0x04 RX_DATA RO; 0x08 CFG RW; 0x0C CTRL RW; 0x10 STT RO; 0x14 INT_EN RW; 0x18 INT_STT W1C.
REQ-015 pslverr_o=1 in access phase for unmapped address, write to RO register, read of WO register, TX push when full, RX pop when empty; else 0.
REQ-016 prdata_o = selected register during read access; 0 otherwise and on error.
REQ-017 RW/W1C registers update only byte lanes with pstrb_i set; unused bits read 0.
REQ-018 TX_DATA write with pstrb_i[0]=1 and TX not full pushes pwdata_i[DATA_W-1:0]; full -> no push, no state change.
REQ-019 tx_valid_o = !tx_empty & CTRL.tx_en; pop when tx_valid_o&tx_ready_i.
REQ-020 RX_DATA read pops RX head; prdata_o[DATA_W-1:0] = head value in the same access cycle.
REQ-021 rx_valid_i&CTRL.rx_en pushes rx_data_i; when full with no pop in that cycle: drop data, set INT_STT.overrun.
REQ-022 Push and pop in the same cycle: both proceed and level is unchanged; fullness checks use pre-cycle state.
REQ-023 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits with wrap bit; full/empty SHALL be derived from them; level in 0..FIFO_DEPTH.
REQ-024 CFG[1:0]/[2]/[3]/[4] drive data_bit_num_o/stop_bit_num_o/parity_en_o/parity_type_o.
REQ-025 CTRL[0] tx_en, [1] rx_en; [2] tx_flush, [3] rx_flush self-clear after one cycle, empty the FIFO; flush beats a same-cycle push.
REQ-026 STT: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [15:8] tx level, [23:16] rx level.
REQ-027 INT_STT sticky bits: [0] tx_done_i, [1] rx push, [2] parity_error_i&rx_valid_i, [3] overrun.
REQ-028 Writing 1 clears an INT_STT bit; a same-cycle set event wins over the clear.
REQ-029 irq_o SHALL be registered: |(INT_STT[3:0]&INT_EN[3:0]), one cycle after the causing bit changes.

Reset
REQ-030 reset_n=0 at a clock edge clears all registers, FIFO pointers and irq_o, and discards in-flight FIFO data.
REQ-031 Reset values: prdata_o 0, pslverr_o 0, tx_valid_o 0, tx_data_o 0, config outputs 0, STT=0x0000_0005.

Verification
REQ-032 Push 8 bytes 0xA0..0xA7, tx_en=0 -> STT.tx_full=1, tx level 8; 9th write -> pslverr_o=1, level stays 8.
REQ-033 Set tx_en, tx_ready_i=1 -> tx_data_o sequence 0xA0..0xA7, one per cycle, then tx_valid_o=0.
REQ-034 Push 9 RX strobes, no reads -> INT_STT=0x0A, irq_o=1 with INT_EN=0x8; reads return first 8 bytes; 9th read -> pslverr_o=1.
REQ-035 RX full, rx_valid_i and RX_DATA read in the same cycle -> no overrun, level stays 8.
REQ-036 Write INT_STT=0x1 in the same cycle as a tx_done_i pulse -> bit 0 stays 1; a later W1C clears it and irq_o drops one cycle later.
REQ-037 reset_n=0 while TX holds 3 entries -> next cycle STT=0x0000_0005, tx_valid_o=0.
